// File: rtl/demux_1to4_stream_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel indices and
// the round-robin pointer step.
package demux_1to4_stream_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    typedef logic [1:0] ch_idx_t;

    // Strict a,b,c,d order; the 2-bit add wraps 3 -> 0 by construction.
    function automatic ch_idx_t next_ch(input ch_idx_t cur);
        return ch_idx_t'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// One-deep output skid register for a single demux channel. A fill in the
// same cycle as a drain replaces the held beat and keeps valid asserted.
module demux_chan_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_fill,
    input  logic [DW-1:0] i_fill_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // Slot register: fill has priority over drain; data is kept after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_data  <= i_fill_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_data  <= r_data;
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer with explicit or round-robin routing,
// a one-deep skid slot per channel and per-channel accepted-beat counters.
module demux_1to4_stream
    import demux_1to4_stream_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode_rr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    input  logic [1:0]              in_sel,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*DW-1:0]    out_data,
    output logic [1:0]              rr_ptr,
    output logic [NUM_CH*CNT_W-1:0] beat_cnt
);

    ch_idx_t           w_tgt;
    logic              w_in_ready;
    logic              w_accept;
    logic [NUM_CH-1:0] w_fill;
    ch_idx_t           r_rr_ptr;
    logic [CNT_W-1:0]  r_beat_cnt [NUM_CH];

    // Target select and accept decode; in_ready is held low during reset and
    // deliberately ignores in_valid.
    always_comb begin
        w_tgt      = mode_rr ? r_rr_ptr : in_sel;
        w_in_ready = rst_n & (~out_valid[w_tgt] | out_ready[w_tgt]);
        w_accept   = in_valid & w_in_ready;
        w_fill     = '0;
        if (w_accept) begin
            w_fill[w_tgt] = 1'b1;
        end else begin
            w_fill = '0;
        end
    end

    // Round-robin pointer moves only on accepted beats in round-robin mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= CH_A;
        end else if (w_accept && mode_rr) begin
            r_rr_ptr <= next_ch(r_rr_ptr);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Per-channel accepted-beat counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_beat_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_fill[k]) begin
                    r_beat_cnt[k] <= r_beat_cnt[k] + CNT_W'(1);
                end else begin
                    r_beat_cnt[k] <= r_beat_cnt[k];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        demux_chan_slot #(
            .DW(DW)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_fill     (w_fill[g]),
            .i_fill_data(in_data),
            .i_ready    (out_ready[g]),
            .o_valid    (out_valid[g]),
            .o_data     (out_data[g*DW +: DW])
        );
        assign beat_cnt[g*CNT_W +: CNT_W] = r_beat_cnt[g];
    end

    assign in_ready = w_in_ready;
    assign rr_ptr   = r_rr_ptr;

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench for demux_1to4_stream: vector table, per-channel
// scoreboard queues and hand-written multi-cycle corner sequences.
module tb_demux_1to4_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_rr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  rr_ptr;
    logic [31:0] beat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: expected occupancy, pointer, counters and data queues.
    logic [3:0] m_valid;
    logic [1:0] m_ptr;
    logic [7:0] m_cnt [4];
    logic [7:0] exp_q [4][$];

    typedef struct {
        logic       m;
        logic       v;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] ordy;
        logic       exp_ir;
        logic [3:0] exp_ov;
    } vec_t;
    vec_t tbl [9];

    demux_1to4_stream #(.DW(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_rr  (mode_rr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .rr_ptr   (rr_ptr),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 4'h0;
        m_ptr   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 8'd0;
            exp_q[k].delete();
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 4'h0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic cycle(input logic m, input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] ordy, output logic ir_seen);
        logic [1:0] t;
        logic       ir_exp;
        logic       acc;
        logic [7:0] e;
        mode_rr   = m;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        #2;
        t       = m ? m_ptr : s;
        ir_exp  = !m_valid[t] || ordy[t];
        ir_seen = in_ready;
        chk("in_ready_model", 32'(in_ready), 32'(ir_exp));
        chk("out_valid_model", 32'(out_valid), 32'(m_valid));
        for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && ordy[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk("sb_unexpected_beat", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q[k].pop_front();
                    chk("sb_data", 32'(out_data[k*8 +: 8]), 32'(e));
                end
            end
        end
        acc = v && ir_exp;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k] && ordy[k]) m_valid[k] = 1'b0;
        end
        if (acc) begin
            m_valid[t] = 1'b1;
            exp_q[t].push_back(d);
            m_cnt[t] = m_cnt[t] + 8'd1;
            if (m) m_ptr = m_ptr + 2'd1;
        end
    endtask

    initial begin
        logic ir;
        logic [31:0] exp_cnt;

        // Reset held with a beat offered.
        rst_n = 1'b0; mode_rr = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
        in_data = 8'hEE; out_ready = 4'hF;
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_beat_cnt", beat_cnt, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_rr_ptr", 32'(rr_ptr), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;

        // Explicit routing then backpressure on channel c.
        tbl[0] = '{1'b0, 1'b1, 2'd0, 8'hA0, 4'hF,    1'b1, 4'b0001};
        tbl[1] = '{1'b0, 1'b1, 2'd1, 8'hA1, 4'hF,    1'b1, 4'b0010};
        tbl[2] = '{1'b0, 1'b1, 2'd2, 8'hA2, 4'hF,    1'b1, 4'b0100};
        tbl[3] = '{1'b0, 1'b1, 2'd3, 8'hA3, 4'hF,    1'b1, 4'b1000};
        tbl[4] = '{1'b0, 1'b1, 2'd2, 8'hB0, 4'b1011, 1'b1, 4'b0100};
        tbl[5] = '{1'b0, 1'b1, 2'd2, 8'hB1, 4'b1011, 1'b0, 4'b0100};
        tbl[6] = '{1'b0, 1'b1, 2'd1, 8'hB2, 4'b1011, 1'b1, 4'b0110};
        tbl[7] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1011, 1'b1, 4'b0100};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'hF,    1'b1, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].m, tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ordy, ir);
            chk("tbl_in_ready", 32'(ir), 32'(tbl[i].exp_ir));
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
        end
        chk("tbl_beat_cnt", beat_cnt, 32'h01_02_02_01);

        // Round-robin a,b,c,d,a,b,c,d with in_sel ignored.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 2'd3, 8'h10 + 8'(i), 4'hF, ir);
            chk("rr_in_ready", 32'(ir), 32'd1);
            chk("rr_out_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
            chk("rr_data", 32'(out_data[(i % 4)*8 +: 8]), 32'(8'h10 + 8'(i)));
        end
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'hF, ir);
        chk("rr_ptr_end", 32'(rr_ptr), 32'd0);
        chk("rr_beat_cnt", beat_cnt, 32'h02_02_02_02);

        // Round-robin stall: full target blocks input, pointer does not skip.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 2'd0, 8'h20 + 8'(i), 4'h0, ir);
        cycle(1'b1, 1'b1, 2'd0, 8'h24, 4'h0, ir);
        chk("rr_stall_ready", 32'(ir), 32'd0);
        chk("rr_stall_ptr", 32'(rr_ptr), 32'd0);
        chk("rr_stall_held", out_data, 32'h23_22_21_20);
        // Mode switch: explicit sel to a still-full channel also stalls; ptr holds.
        cycle(1'b0, 1'b1, 2'd2, 8'h25, 4'h0, ir);
        chk("mode_sw_ready", 32'(ir), 32'd0);
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, ir);
        chk("rr_drained", 32'(out_valid), 32'd0);

        // Drain and fill on channel a every cycle.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 2'd0, 8'h30 + 8'(i), 4'hF, ir);
            chk("df_in_ready", 32'(ir), 32'd1);
            chk("df_valid", 32'(out_valid[0]), 32'd1);
            chk("df_data", 32'(out_data[7:0]), 32'(8'h30 + 8'(i)));
        end
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, ir);
        chk("df_empty", 32'(out_valid), 32'd0);
        chk("df_queue_empty", 32'(exp_q[0].size()), 32'd0);

        // Counter wrap on channel d.
        do_reset();
        for (int i = 0; i < 255; i++) cycle(1'b0, 1'b1, 2'd3, 8'(i), 4'hF, ir);
        exp_cnt = 32'hFF00_0000;
        chk("cnt_255", beat_cnt, exp_cnt);
        cycle(1'b0, 1'b1, 2'd3, 8'hC3, 4'hF, ir);
        chk("cnt_wrap", beat_cnt, 32'd0);
        chk("cnt_model", 32'(m_cnt[3]), 32'd0);

        // Async reset between clock edges while a beat is held.
        cycle(1'b0, 1'b1, 2'd3, 8'h5A, 4'h0, ir);
        chk("pre_rst_valid", 32'(out_valid), 32'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_beat_cnt", beat_cnt, 32'd0);
        chk("arst_rr_ptr", 32'(rr_ptr), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
